// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if
//   Bundles the scanned display bus and the decoded result of one
//   seg_scan_decoder instance.
//
// Signals:
//   anode_vec   [3:0]  scanned anode bus [AN3 AN2 AN1 AN0] (raw polarity)
//   cathode_vec [6:0]  scanned cathode bus [CA..CG] (raw polarity)
//   err_clr            synchronous clear of the sticky error flags
//   min, sec    [5:0]  last good decoded minutes / seconds
//   frame_valid        one-cycle strobe when min/sec update
//   locked             frames are decoding cleanly
//   seg_err, seq_err   sticky error flags
//   state_dbg   [0:0]  current framing state (0 = hunting, 1 = collecting)
//
// Handshake: frame_valid is a pure one-cycle valid strobe with no ready.
// min/sec are stable from the strobe cycle until the next strobe, so a
// consumer may sample them on the strobe or at any later time.
//
// Modports:
//   master - display side / monitor host (drives the bus, reads results)
//   slave  - the decoder
interface seg_scan_decoder_if;
  logic [3:0] anode_vec;
  logic [6:0] cathode_vec;
  logic       err_clr;
  logic [5:0] min;
  logic [5:0] sec;
  logic       frame_valid;
  logic       locked;
  logic       seg_err;
  logic       seq_err;
  logic [0:0] state_dbg;

  modport master (
    output anode_vec, cathode_vec, err_clr,
    input  min, sec, frame_valid, locked, seg_err, seq_err, state_dbg
  );

  modport slave (
    input  anode_vec, cathode_vec, err_clr,
    output min, sec, frame_valid, locked, seg_err, seq_err, state_dbg
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side monitor for a multiplexed 4-digit 7-segment display.
//   Registers the scanned anode/cathode bus, decodes each segment pattern
//   back to a BCD digit, tracks the AN0..AN3 scan order and reassembles
//   one frame into binary min/sec. Framing and glyph errors are flagged
//   with sticky flags and drop the locked indication.
//
// Ports:
//   fast_clk  scan clock, all logic on its rising edge
//   rst_n     asynchronous active-low reset
//   bus       seg_scan_decoder_if.slave (scan bus in, decoded results out)
//
// Parameters:
//   ANODE_ACTIVE_LOW  1 = anode bus inverted at the input register
//   SEG_ACTIVE_LOW    1 = cathode bus inverted at the input register
//   MAX_HOLD          max consecutive repeats of one anode before timeout
module seg_scan_decoder #(
  parameter logic ANODE_ACTIVE_LOW = 1'b0,
  parameter logic SEG_ACTIVE_LOW   = 1'b0,
  parameter int   MAX_HOLD         = 15
) (
  input logic               fast_clk,
  input logic               rst_n,
  seg_scan_decoder_if.slave bus
);

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  // Counter must hold MAX_HOLD+1 so the overflow compare is exact.
  localparam int            HW       = $clog2(MAX_HOLD + 2);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

  // Stage 0: input register, normalised to active-high.
  logic [3:0] an_q;
  logic [6:0] ca_q;

  // Stage 1 decode results.
  logic       pat_ok;
  logic [3:0] pat_dig;
  logic       is_onehot;
  logic [1:0] pos;

  // Framing state.
  logic [0:0]    state, state_n;
  logic [1:0]    exp_pos, exp_n;
  logic [1:0]    last_pos, last_n;
  logic [HW-1:0] hold_cnt, hold_n, hold_inc;
  logic [3:0]    dig [4];

  logic       cap, complete, seg_hit, seq_hit;
  logic [6:0] min_chk;
  logic [6:0] min_frame, sec_frame;

  // Output stage.
  logic       done;
  logic [5:0] min_r, sec_r;
  logic       fv_r, locked_r, seg_err_r, seq_err_r;

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q <= '0;
      ca_q <= '0;
    end else begin
      an_q <= bus.anode_vec ^ {4{ANODE_ACTIVE_LOW}};
      ca_q <= bus.cathode_vec ^ {7{SEG_ACTIVE_LOW}};
    end
  end

  // Glyph decode; 0110111 is the driver's blank glyph and is rejected
  // along with every other unlisted pattern.
  always_comb begin
    pat_ok  = 1'b1;
    pat_dig = 4'd0;
    case (ca_q)
      7'b1111110: pat_dig = 4'd0;
      7'b0110000: pat_dig = 4'd1;
      7'b1101101: pat_dig = 4'd2;
      7'b1111001: pat_dig = 4'd3;
      7'b0110011: pat_dig = 4'd4;
      7'b1011011: pat_dig = 4'd5;
      7'b1011111: pat_dig = 4'd6;
      7'b1110000: pat_dig = 4'd7;
      7'b1111111: pat_dig = 4'd8;
      7'b1110011: pat_dig = 4'd9;
      default:    pat_ok  = 1'b0;
    endcase
  end

  always_comb begin
    is_onehot = 1'b1;
    pos       = 2'd0;
    case (an_q)
      4'b0001: pos = 2'd0;
      4'b0010: pos = 2'd1;
      4'b0100: pos = 2'd2;
      4'b1000: pos = 2'd3;
      default: is_onehot = 1'b0;
    endcase
  end

  // Minutes as they would be if the current sample closes the frame.
  assign min_chk   = {3'b000, pat_dig} * 7'd10 + {3'b000, dig[2]};
  assign min_frame = {3'b000, dig[3]} * 7'd10 + {3'b000, dig[2]};
  assign sec_frame = {3'b000, dig[1]} * 7'd10 + {3'b000, dig[0]};
  assign hold_inc  = hold_cnt + HW'(1);

  always_comb begin
    state_n  = state;
    exp_n    = exp_pos;
    last_n   = last_pos;
    hold_n   = hold_cnt;
    cap      = 1'b0;
    complete = 1'b0;
    seg_hit  = 1'b0;
    seq_hit  = 1'b0;
    case (state)
      ST_HUNT: begin
        hold_n = '0;
        if (an_q == 4'b0001 && pat_ok) begin
          cap     = 1'b1;
          exp_n   = 2'd1;
          last_n  = 2'd0;
          state_n = ST_COLLECT;
        end
      end
      default: begin
        if (!is_onehot) begin
          seq_hit = 1'b1;
        end else if (!pat_ok) begin
          seg_hit = 1'b1;
        end else if (pos == last_pos) begin
          // Same digit still being displayed: must be stable and bounded.
          if (pat_dig != dig[last_pos]) seq_hit = 1'b1;
          else if (hold_inc > HOLD_LIM) seq_hit = 1'b1;
          else hold_n = hold_inc;
        end else if (pos == exp_pos) begin
          // Closing digit: reject frames whose tens digits or minutes
          // cannot be a legal mm:ss value.
          if (pos == 2'd3 &&
              (dig[1] > 4'd5 || pat_dig > 4'd6 || min_chk > 7'd63)) begin
            seg_hit = 1'b1;
          end else begin
            cap      = 1'b1;
            hold_n   = '0;
            exp_n    = exp_pos + 2'd1;
            last_n   = pos;
            complete = (pos == 2'd3);
          end
        end else begin
          seq_hit = 1'b1;
        end
        if (seg_hit || seq_hit) begin
          state_n = ST_HUNT;
          hold_n  = '0;
          exp_n   = 2'd0;
          last_n  = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HUNT;
      exp_pos  <= 2'd0;
      last_pos <= 2'd0;
      hold_cnt <= '0;
      for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
    end else begin
      state    <= state_n;
      exp_pos  <= exp_n;
      last_pos <= last_n;
      hold_cnt <= hold_n;
      if (cap) dig[pos] <= pat_dig;
    end
  end

  // Output stage: a completed frame is published one edge after capture.
  // An error in that same edge still wins on locked.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      min_r     <= '0;
      sec_r     <= '0;
      fv_r      <= 1'b0;
      locked_r  <= 1'b0;
      seg_err_r <= 1'b0;
      seq_err_r <= 1'b0;
    end else begin
      done <= complete;
      fv_r <= done;
      if (done) begin
        min_r <= min_frame[5:0];
        sec_r <= sec_frame[5:0];
      end
      if (seg_hit || seq_hit) locked_r <= 1'b0;
      else if (done)          locked_r <= 1'b1;
      seg_err_r <= seg_hit | (seg_err_r & ~bus.err_clr);
      seq_err_r <= seq_hit | (seq_err_r & ~bus.err_clr);
    end
  end

  assign bus.min         = min_r;
  assign bus.sec         = sec_r;
  assign bus.frame_valid = fv_r;
  assign bus.locked      = locked_r;
  assign bus.seg_err     = seg_err_r;
  assign bus.seq_err     = seq_err_r;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Drives scanned display traffic into seg_scan_decoder and compares every
//   cycle against a frame-level reference model that keeps the digits of
//   the frame in progress in a queue.
module tb_seg_scan_decoder;

  localparam logic AAL  = 1'b1;
  localparam logic SAL  = 1'b0;
  localparam int   MAXH = 15;

  localparam logic [6:0] GLYPH [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011
  };
  localparam logic [6:0] BLANK = 7'b0110111;

  // ---------------- clock / reset ----------------
  logic fast_clk = 1'b0;
  logic rst_n    = 1'b1;
  always #5 fast_clk = ~fast_clk;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .ANODE_ACTIVE_LOW(AAL),
    .SEG_ACTIVE_LOW  (SAL),
    .MAX_HOLD        (MAXH)
  ) dut (
    .fast_clk(fast_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];      // expected {min, sec} per published frame

  int   fr[$];                // digits of the frame in progress, pos order
  bit   hunting;
  int   hold;
  logic [3:0] p_an;           // sample sitting in the input register
  logic [6:0] p_ca;
  bit   pend;
  int   pend_min, pend_sec;
  int   m_min, m_sec;
  bit   m_fv, m_locked, m_seg, m_seq;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int glyph_val(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (GLYPH[i] == p) return i;
    return -1;
  endfunction

  function automatic int anode_pos(input logic [3:0] a);
    if ($countones(a) != 1) return -1;
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    fr.delete();
    exp_q.delete();
    hunting  = 1'b1;
    hold     = 0;
    p_an     = '0;
    p_ca     = '0;
    pend     = 1'b0;
    m_min    = 0;
    m_sec    = 0;
    m_fv     = 1'b0;
    m_locked = 1'b0;
    m_seg    = 1'b0;
    m_seq    = 1'b0;
  endtask

  // Frame rules applied to one registered sample.
  task automatic model_fsm(input logic [3:0] an, input logic [6:0] ca,
                           output bit seg_e, output bit seq_e);
    int d, p, m7;
    seg_e = 1'b0;
    seq_e = 1'b0;
    d = glyph_val(ca);
    p = anode_pos(an);
    if (hunting) begin
      if (p == 0 && d >= 0) begin
        fr.delete();
        fr.push_back(d);
        hunting = 1'b0;
        hold    = 0;
      end
      return;
    end
    if (p < 0) seq_e = 1'b1;
    else if (d < 0) seg_e = 1'b1;
    else if (p == fr.size() - 1) begin
      if (d != fr[p]) seq_e = 1'b1;
      else if (hold + 1 > MAXH) seq_e = 1'b1;
      else hold++;
    end else if (p == fr.size() % 4) begin
      if (p == 0) fr.delete();
      if (p == 3) begin
        m7 = d * 10 + fr[2];
        if (fr[1] > 5 || d > 6 || m7 > 63) seg_e = 1'b1;
        else begin
          pend     = 1'b1;
          pend_min = m7;
          pend_sec = fr[1] * 10 + fr[0];
          exp_q.push_back({6'(pend_min), 6'(pend_sec)});
        end
      end
      if (!seg_e) begin
        fr.push_back(d);
        hold = 0;
      end
    end else seq_e = 1'b1;
    if (seg_e || seq_e) begin
      hunting = 1'b1;
      fr.delete();
      hold = 0;
    end
  endtask

  task automatic model_edge(input logic clr);
    bit se, qe;
    m_fv = pend;
    if (pend) begin
      m_min = pend_min;
      m_sec = pend_sec;
    end
    pend = 1'b0;
    model_fsm(p_an, p_ca, se, qe);
    m_seg = se | (m_seg & !clr);
    m_seq = qe | (m_seq & !clr);
    if (se || qe) m_locked = 1'b0;
    else if (m_fv) m_locked = 1'b1;
  endtask

  task automatic compare();
    logic [11:0] e;
    check("frame_valid", bus.frame_valid, m_fv);
    check("locked", bus.locked, m_locked);
    check("seg_err", bus.seg_err, m_seg);
    check("seq_err", bus.seq_err, m_seq);
    check("min", bus.min, m_min);
    check("sec", bus.sec, m_sec);
    if (bus.frame_valid === 1'b1) begin
      if (exp_q.size() == 0) check("fv_spurious", bus.frame_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("frame_min_sec", {bus.min, bus.sec}, e);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [3:0] an, input logic [6:0] pat,
                       input logic clr);
    bus.anode_vec   = an ^ {4{AAL}};
    bus.cathode_vec = pat ^ {7{SAL}};
    bus.err_clr     = clr;
    @(posedge fast_clk);
    model_edge(clr);
    p_an = an;
    p_ca = pat;
    @(negedge fast_clk);
    compare();
  endtask

  task automatic show(input int p, input int dig, input int n);
    logic [3:0] an;
    an = 4'(1 << p);
    for (int i = 0; i < n; i++) cycle(an, GLYPH[dig], 1'b0);
  endtask

  task automatic send_frame(input int d0, input int d1, input int d2,
                            input int d3);
    show(0, d0, $urandom_range(1, 4));
    show(1, d1, $urandom_range(1, 4));
    show(2, d2, $urandom_range(1, 4));
    show(3, d3, $urandom_range(1, 4));
  endtask

  task automatic send_time(input int m, input int s);
    send_frame(s % 10, s / 10, m % 10, m / 10);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    repeat (2) @(negedge fast_clk);
    compare();
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.anode_vec   = 4'b0000 ^ {4{AAL}};
    bus.cathode_vec = 7'd0 ^ {7{SAL}};
    bus.err_clr     = 1'b0;
    model_reset();
    #1;
    apply_reset();

    // Scan picked up mid-frame, then clean 12:34 frames.
    show(2, 2, 2);
    show(3, 1, 2);
    repeat (3) send_frame(4, 3, 2, 1);

    // Blank glyph at AN1, then a clean 59:59, then clear.
    show(0, 4, 2);
    cycle(4'b0010, BLANK, 1'b0);
    cycle(4'b0010, BLANK, 1'b0);
    send_time(59, 59);
    cycle(4'b0000, 7'd0, 1'b1);

    // Order violation, non-one-hot anode, hold timeout.
    show(0, 1, 1);
    show(2, 1, 1);
    show(0, 3, 2);
    cycle(4'b0011, GLYPH[3], 1'b0);
    show(0, 5, 1);
    show(1, 2, 17);
    cycle(4'b0000, 7'd0, 1'b1);

    // Out-of-range tens digits.
    send_frame(0, 7, 0, 0);
    send_frame(0, 0, 0, 7);
    cycle(4'b0000, 7'd0, 1'b1);

    // Reset in the middle of 45:10, then the full frame.
    send_time(23, 17);
    show(0, 0, 2);
    show(1, 1, 2);
    apply_reset();
    send_time(45, 10);
    send_time(45, 10);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      int kind, k, d3;
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: send_time($urandom_range(0, 59), $urandom_range(0, 59));
        4: begin
          k = $urandom_range(0, 3);
          for (int p = 0; p < 4; p++) begin
            if (p == k) cycle(4'(1 << p), 7'($urandom_range(0, 127)), 1'b0);
            else show(p, $urandom_range(0, 9), $urandom_range(1, 3));
          end
        end
        5: cycle(4'($urandom_range(0, 15)), GLYPH[$urandom_range(0, 9)], 1'b0);
        6: cycle(4'b0001, GLYPH[$urandom_range(0, 9)], 1'b1);
        7: begin
          d3 = $urandom_range(0, 9);
          if (d3 == 6) d3 = 7;
          send_frame($urandom_range(0, 9), $urandom_range(0, 9),
                     $urandom_range(0, 9), d3);
        end
        8: begin
          show(0, $urandom_range(0, 9), 1);
          show(1, $urandom_range(0, 9), $urandom_range(14, 18));
        end
        default: begin
          show(0, 2, 1);
          show(0, 3, 1);
        end
      endcase
    end

    repeat (4) cycle(4'b0000, 7'd0, 1'b0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
